// File: rtl/mimo_gather_8_if.sv
// Branch-side and vector-side signals of the 8-lane gather block.
// MIMO_GATHER_8_COLLISION_EN adds the o_collision_count statistic.
interface mimo_gather_8_if #(
    parameter int WIDTH = 16
);
    logic [7:0][WIDTH-1:0] i_data;
    logic [7:0][2:0]       i_lane;
    logic [7:0]            i_valid;
    logic [7:0]            o_ready;
    logic [7:0][WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
`ifdef MIMO_GATHER_8_COLLISION_EN
    logic [15:0]           o_collision_count;
`endif

    // slave is the gather block, master is whoever drives the branches and consumes vectors
    modport slave (
        input  i_data, i_lane, i_valid, i_ready,
        output o_ready, o_data, o_valid
`ifdef MIMO_GATHER_8_COLLISION_EN
        , output o_collision_count
`endif
    );

    modport master (
        output i_data, i_lane, i_valid, i_ready,
        input  o_ready, o_data, o_valid
`ifdef MIMO_GATHER_8_COLLISION_EN
        , input o_collision_count
`endif
    );
endinterface

// File: rtl/mimo_gather_8.sv
// Double-buffered gather: lane-tagged words from 8 branches are reassembled into 8-lane vectors.
// MIMO_GATHER_8_COLLISION_EN adds a saturating count of lane-collision stall cycles.
module mimo_gather_8 #(
    parameter int WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    mimo_gather_8_if.slave   bus
);

    logic [1:0][7:0]            mask;
    logic [1:0][7:0][WIDTH-1:0] bank;
    logic                       wr_sel;
    logic                       rd_sel;

    logic       wr_full;
    logic       rd_full;
    logic       read_fire;
    logic [7:0] accept;
    logic [7:0] claim;

    // claim starts as the write bank's mask; each winner marks its lane so later branches lose it
    always_comb begin
        wr_full = (mask[wr_sel] == 8'hFF);
        rd_full = (mask[rd_sel] == 8'hFF);
        claim   = mask[wr_sel];
        accept  = '0;
        for (int k = 0; k < 8; k++) begin
            if (i_reset_n && bus.i_valid[k] && !wr_full && !claim[bus.i_lane[k]]) begin
                accept[k]              = 1'b1;
                claim[bus.i_lane[k]]   = 1'b1;
            end
        end
        read_fire = rd_full && bus.i_ready;
    end

    assign bus.o_ready = accept;
    assign bus.o_valid = rd_full;
    assign bus.o_data  = bank[rd_sel];

    // read-clear comes last so it wins when both banks are full and rd_sel equals wr_sel
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mask   <= '0;
            bank   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept[k]) begin
                    bank[wr_sel][bus.i_lane[k]] <= bus.i_data[k];
                end
            end
            if (!wr_full) begin
                mask[wr_sel] <= claim;
                if (claim == 8'hFF) begin
                    wr_sel <= ~wr_sel;
                end
            end
            if (read_fire) begin
                mask[rd_sel] <= '0;
                rd_sel       <= ~rd_sel;
            end
        end
    end

`ifdef MIMO_GATHER_8_COLLISION_EN
    logic [15:0] collision_count;
    logic        collide;

    // a full write bank blocks everyone, which is backpressure rather than a collision
    assign collide = !wr_full && |(bus.i_valid & ~accept);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            collision_count <= '0;
        end else if (collide && collision_count != 16'hFFFF) begin
            collision_count <= collision_count + 16'd1;
        end
    end

    assign bus.o_collision_count = collision_count;
`endif

endmodule
